mul_sequencer: RTL and testbench
================================

Name: mul_sequencer

Overview:
- Issue/writeback sequencer directly upstream and downstream of the sequential 8x8 multiplier in NEANDER-X.
- On a MUL request from the control unit it:
  - latches AC and X as operands;
  - pulses the multiplier start;
  - waits for the multiplier's done pulse;
  - writes the 16-bit product back (low byte to AC, high byte to Y) and updates the N/Z/C flags.
- Stalls the control unit for the whole operation and runs a watchdog so a hung multiplier cannot lock the CPU.

Parameters:
- TIMEOUT_CYCLES, 15, WAIT-state cycles allowed before mul_done must arrive; legal range 10..255.
- WRITE_HIGH, 1, 1: high byte written to Y; 0: y_we never asserted.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- op_valid  input  1  MUL request from control unit.
- op_ready  output  1  sequencer can accept a request.
- ac_in  input  8  AC value, multiplicand.
- x_in  input  8  X value, multiplier.
- mul_start  output  1  one-cycle start pulse to the multiplier.
- mul_multiplicand  output  8  latched multiplicand.
- mul_multiplier  output  8  latched multiplier.
- mul_product_low  input  8  multiplier result bits 7:0.
- mul_product_high  input  8  multiplier result bits 15:8.
- mul_done  input  1  multiplier result-ready pulse.
- ac_we  output  1  AC write enable (one-cycle pulse).
- ac_wdata  output  8  product low byte.
- y_we  output  1  Y write enable (one-cycle pulse).
- y_wdata  output  8  product high byte.
- flag_we  output  1  flag write enable (one-cycle pulse).
- flag_n  output  1  product bit 7.
- flag_z  output  1  16-bit product == 0.
- flag_c  output  1  product high byte != 0.
- stall  output  1  hold control unit.
- op_done  output  1  one-cycle completion pulse.
- timeout_err  output  1  one-cycle watchdog-error pulse.

Behaviour:

Interface:
- One clock, clk.
- Reset is synchronous and active-high on the port named reset.

Reset:
- State goes to IDLE.
- Every output register and internal register goes to 0.
- op_ready=1 combinationally once in IDLE; stall=0.
- Reset mid-operation aborts with no writeback and no pulses.
- The multiplier shares the reset net and aborts too.

States:

IDLE:
- op_ready=1, stall=0.
- Transfer when op_valid=1: latch ac_in/x_in into operand registers, go to ISSUE.

ISSUE:
- mul_start=1 for exactly this cycle; timeout counter cleared.
- Go to WAIT.

WAIT:
- Counter increments each cycle.
- mul_done=1: capture {mul_product_high, mul_product_low} into a 16-bit result register, go to WB.
- Else, if counter reaches TIMEOUT_CYCLES: go to ERR.

WB:
- ac_we=1, flag_we=1, op_done=1; y_we=WRITE_HIGH.
- Write data and flags come from the captured result register.
- Go to IDLE.

ERR:
- timeout_err=1; no register or flag writes.
- Go to IDLE.

Outputs and handshake:
- stall = (state != IDLE); op_ready = (state == IDLE).
- op_valid outside IDLE is ignored; no queueing.
- mul_done outside WAIT is ignored.
- mul_multiplicand/mul_multiplier are held constant from the cycle after acceptance until return to IDLE.
- ac_wdata/y_wdata/flag_* are driven from the result register and are valid whenever the corresponding we is high.

Flags:
- n = result[7].
- z = (result[15:0] == 0).
- c = |result[15:8].

Latency:
- Acceptance in cycle T gives mul_start at T+1.
- The team multiplier gives mul_done at T+10, so WB/op_done is at T+11 and op_ready is back at T+12.

Back-to-back operation:
- A request held high through WB is accepted in the first IDLE cycle (T+12).

Watchdog:
- Counter is 8 bits.
- mul_done arriving in the same cycle the count hits TIMEOUT_CYCLES wins: go to WB, not ERR.

Test Plan:
1. ac_in=0x0D, x_in=0x0B, op_valid pulse at T:
   - mul_start at T+1.
   - At T+11: ac_we=1, ac_wdata=0x8F, y_we=1, y_wdata=0x00, n=1, z=0, c=0, op_done=1.
   - stall high T+1..T+11.
2. 0xFF x 0xFF: ac_wdata=0x01, y_wdata=0xFE, n=0, z=0, c=1. Also 0x00 x 0xC8: ac_wdata=0x00, y_wdata=0x00, z=1, c=0.
3. op_valid held high, operands 3x4 then 5x6:
   - First op gives 0x0C at T+11.
   - Second accepted at T+12, gives 0x1E at T+23.
   - op_valid during busy cycles has no effect.
4. Multiplier stub never asserts mul_done, TIMEOUT_CYCLES=15:
   - timeout_err=1 for one cycle at T+17.
   - No ac_we/y_we/flag_we; op_ready=1 at T+18.
   - mul_done at exactly the 15th WAIT cycle produces WB instead.
5. reset asserted at T+5 (in WAIT):
   - Next cycle: state IDLE, all outputs 0, op_ready=1.
   - No ac_we or op_done afterwards, even if a stale mul_done arrives.
6. WRITE_HIGH=0, 0x80 x 0x04:
   - ac_wdata=0x00, c=1, z=0.
   - y_we stays 0 throughout.

Source files
------------

// File: rtl/mul_sequencer_if.sv
// Signal bundle between the MUL sequencer, the control unit/register file and the
// sequential 8x8 multiplier. The sequencer takes the slave side.
interface mul_sequencer_if;
    logic       op_valid;
    logic       op_ready;
    logic [7:0] ac_in;
    logic [7:0] x_in;
    logic       mul_start;
    logic [7:0] mul_multiplicand;
    logic [7:0] mul_multiplier;
    logic [7:0] mul_product_low;
    logic [7:0] mul_product_high;
    logic       mul_done;
    logic       ac_we;
    logic [7:0] ac_wdata;
    logic       y_we;
    logic [7:0] y_wdata;
    logic       flag_we;
    logic       flag_n;
    logic       flag_z;
    logic       flag_c;
    logic       stall;
    logic       op_done;
    logic       timeout_err;

    modport master (
        output op_valid, ac_in, x_in, mul_product_low, mul_product_high, mul_done,
        input  op_ready, mul_start, mul_multiplicand, mul_multiplier,
               ac_we, ac_wdata, y_we, y_wdata, flag_we, flag_n, flag_z, flag_c,
               stall, op_done, timeout_err
    );

    modport slave (
        input  op_valid, ac_in, x_in, mul_product_low, mul_product_high, mul_done,
        output op_ready, mul_start, mul_multiplicand, mul_multiplier,
               ac_we, ac_wdata, y_we, y_wdata, flag_we, flag_n, flag_z, flag_c,
               stall, op_done, timeout_err
    );
endinterface

// File: rtl/mul_sequencer.sv
// Issue/writeback sequencer around the sequential multiplier: latches operands,
// starts the multiplier, waits for done under a watchdog and writes the product back.
module mul_sequencer #(
    parameter int TIMEOUT_CYCLES = 15,
    parameter bit WRITE_HIGH     = 1'b1
) (
    input logic         clk,
    input logic         reset,
    mul_sequencer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WB, ERR} state_t;

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

    state_t      state_reg, state_next;
    logic [7:0]  count_reg, count_next;
    logic [7:0]  mcand_reg, mplier_reg;
    logic [15:0] result_reg;
    logic        accept, capture, wb_active;
    logic [7:0]  wdata_lo, wdata_hi;

    assign accept    = (state_reg == IDLE) && bus.op_valid;
    assign capture   = (state_reg == WAIT) && bus.mul_done;
    assign wb_active = (state_reg == WB);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            count_reg  <= 8'd0;
            mcand_reg  <= 8'd0;
            mplier_reg <= 8'd0;
            result_reg <= 16'd0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            if (accept) begin
                mcand_reg  <= bus.ac_in;
                mplier_reg <= bus.x_in;
            end
            if (capture) begin
                result_reg <= {bus.mul_product_high, bus.mul_product_low};
            end
        end
    end

    // A done pulse in the same cycle the watchdog expires still wins.
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        case (state_reg)
            IDLE:  if (bus.op_valid) state_next = ISSUE;
            ISSUE: begin
                count_next = 8'd0;
                state_next = WAIT;
            end
            WAIT: begin
                count_next = count_reg + 8'd1;
                if (bus.mul_done) begin
                    state_next = WB;
                end else if (count_next == TIMEOUT_LIMIT) begin
                    state_next = ERR;
                end
            end
            WB:      state_next = IDLE;
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Write data is forced to zero outside writeback so idle outputs read as 0.
    for (genvar gi = 0; gi < 8; gi++) begin : g_wdata
        assign wdata_lo[gi] = result_reg[gi]     & wb_active;
        assign wdata_hi[gi] = result_reg[gi + 8] & wb_active;
    end

    always_comb begin
        bus.op_ready         = (state_reg == IDLE);
        bus.stall            = (state_reg != IDLE);
        bus.mul_start        = (state_reg == ISSUE);
        bus.mul_multiplicand = mcand_reg;
        bus.mul_multiplier   = mplier_reg;
        bus.ac_we            = wb_active;
        bus.flag_we          = wb_active;
        bus.op_done          = wb_active;
        bus.y_we             = wb_active && WRITE_HIGH;
        bus.ac_wdata         = wdata_lo;
        bus.y_wdata          = wdata_hi;
        bus.flag_n           = wdata_lo[7];
        bus.flag_z           = wb_active && (result_reg == 16'd0);
        bus.flag_c           = |wdata_hi;
        bus.timeout_err      = (state_reg == ERR);
    end
endmodule

// File: tb/tb_mul_sequencer.sv
// Directed bench for mul_sequencer: a behavioural multiplier stub feeds two DUTs
// (WRITE_HIGH=1 and WRITE_HIGH=0) driven with identical stimulus.
module tb_mul_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mul_sequencer_if b0();
    mul_sequencer_if b1();

    mul_sequencer #(.TIMEOUT_CYCLES(15), .WRITE_HIGH(1'b1)) dut (
        .clk(clk), .reset(reset), .bus(b0.slave));
    mul_sequencer #(.TIMEOUT_CYCLES(15), .WRITE_HIGH(1'b0)) dut_nh (
        .clk(clk), .reset(reset), .bus(b1.slave));

    typedef struct {
        logic [7:0] ac;
        logic [7:0] x;
        logic [7:0] lo;
        logic [7:0] hi;
        logic       n;
        logic       z;
        logic       c;
    } vec_t;

    vec_t vecs[6];
    int vectors = 0;
    int miscompares = 0;

    // Multiplier stub: done arrives stub_delay cycles after the start cycle; 0 = hang.
    int          stub_delay = 9;
    int          rem = 0;
    bit          active = 0;
    logic        done_model = 1'b0;
    logic [15:0] prod = 16'd0;

    always @(negedge clk) begin
        done_model = 1'b0;
        if (active) begin
            rem--;
            if (rem == 0) begin
                done_model = 1'b1;
                active     = 0;
            end
        end
        if (b0.mul_start && stub_delay != 0) begin
            active = 1;
            rem    = stub_delay;
            prod   = b0.mul_multiplicand * b0.mul_multiplier;
        end
    end

    assign b0.mul_done         = done_model;
    assign b0.mul_product_low  = prod[7:0];
    assign b0.mul_product_high = prod[15:8];
    assign b1.op_valid         = b0.op_valid;
    assign b1.ac_in            = b0.ac_in;
    assign b1.x_in             = b0.x_in;
    assign b1.mul_done         = b0.mul_done;
    assign b1.mul_product_low  = b0.mul_product_low;
    assign b1.mul_product_high = b0.mul_product_high;

    int ac_we_cnt = 0, op_done_cnt = 0, flag_we_cnt = 0, nh_y_we_cnt = 0;
    always @(posedge clk) begin
        if (b0.ac_we)   ac_we_cnt++;
        if (b0.op_done) op_done_cnt++;
        if (b0.flag_we) flag_we_cnt++;
        if (b1.y_we)    nh_y_we_cnt++;
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic accept_op(input logic [7:0] a, input logic [7:0] x);
        check("op_ready_before", b0.op_ready, 1'b1);
        b0.op_valid = 1'b1;
        b0.ac_in    = a;
        b0.x_in     = x;
        @(negedge clk);
        b0.op_valid = 1'b0;
    endtask

    // Standard op: starts at a negedge in IDLE (cycle T), ends at negedge of T+12.
    task automatic run_op(input vec_t v);
        int bad = 0;
        accept_op(v.ac, v.x);
        check("mul_start", b0.mul_start, 1'b1);
        check("multiplicand", b0.mul_multiplicand, v.ac);
        check("multiplier", b0.mul_multiplier, v.x);
        for (int c = 2; c <= 11; c++) begin
            @(negedge clk);
            if (c <= 10 && (b0.stall !== 1'b1 || b0.ac_we !== 1'b0 || b0.op_done !== 1'b0
                            || b0.mul_start !== 1'b0))
                bad++;
        end
        check("busy_cycles", 16'(bad), 16'd0);
        check("ac_we", b0.ac_we, 1'b1);
        check("ac_wdata", b0.ac_wdata, v.lo);
        check("y_we", b0.y_we, 1'b1);
        check("y_wdata", b0.y_wdata, v.hi);
        check("flag_we", b0.flag_we, 1'b1);
        check("flag_n", b0.flag_n, v.n);
        check("flag_z", b0.flag_z, v.z);
        check("flag_c", b0.flag_c, v.c);
        check("op_done", b0.op_done, 1'b1);
        check("stall_wb", b0.stall, 1'b1);
        check("nh_ac_wdata", b1.ac_wdata, v.lo);
        check("nh_flag_c", b1.flag_c, v.c);
        check("nh_flag_z", b1.flag_z, v.z);
        check("nh_y_we", b1.y_we, 1'b0);
        $display("op %02h x %02h -> ac=%02h y=%02h n=%0b z=%0b c=%0b", v.ac, v.x,
                 b0.ac_wdata, b0.y_wdata, b0.flag_n, b0.flag_z, b0.flag_c);
        @(negedge clk);
        check("op_ready_after", b0.op_ready, 1'b1);
        check("stall_after", b0.stall, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        int a0, d0, f0, bad;
        vecs[0] = '{8'h0D, 8'h0B, 8'h8F, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{8'h00, 8'hC8, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{8'h80, 8'h04, 8'h00, 8'h02, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{8'h10, 8'h10, 8'h00, 8'h01, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{8'h0C, 8'h0B, 8'h84, 8'h00, 1'b1, 1'b0, 1'b0};

        b0.op_valid = 1'b0;
        b0.ac_in    = 8'h00;
        b0.x_in     = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_op_ready", b0.op_ready, 1'b1);
        check("rst_stall", b0.stall, 1'b0);
        check("rst_ac_we", b0.ac_we, 1'b0);
        check("rst_flag_z", b0.flag_z, 1'b0);
        check("rst_timeout", b0.timeout_err, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_op(vecs[i]);

        // Back-to-back with op_valid held: 3x4 then 5x6.
        b0.op_valid = 1'b1;
        b0.ac_in    = 8'h03;
        b0.x_in     = 8'h04;
        @(negedge clk);
        b0.ac_in = 8'h05;
        b0.x_in  = 8'h06;
        check("b2b_start1", b0.mul_start, 1'b1);
        repeat (4) @(negedge clk);
        check("b2b_hold_mcand", b0.mul_multiplicand, 8'h03);
        check("b2b_hold_mplier", b0.mul_multiplier, 8'h04);
        repeat (6) @(negedge clk);
        check("b2b_wb1", b0.ac_wdata, 8'h0C);
        check("b2b_done1", b0.op_done, 1'b1);
        $display("op 03 x 04 -> ac=%02h (held request)", b0.ac_wdata);
        @(negedge clk);
        check("b2b_ready12", b0.op_ready, 1'b1);
        @(negedge clk);
        b0.op_valid = 1'b0;
        check("b2b_start2", b0.mul_start, 1'b1);
        check("b2b_mcand2", b0.mul_multiplicand, 8'h05);
        repeat (10) @(negedge clk);
        check("b2b_wb2", b0.ac_wdata, 8'h1E);
        check("b2b_done2", b0.op_done, 1'b1);
        $display("op 05 x 06 -> ac=%02h (accepted at T+12)", b0.ac_wdata);
        @(negedge clk);

        // Watchdog: multiplier never answers.
        stub_delay = 0;
        a0 = ac_we_cnt; f0 = flag_we_cnt; bad = 0;
        accept_op(8'h0D, 8'h0B);
        for (int c = 2; c <= 17; c++) begin
            @(negedge clk);
            if (c <= 16 && (b0.timeout_err !== 1'b0 || b0.stall !== 1'b1)) bad++;
        end
        check("wd_wait_cycles", 16'(bad), 16'd0);
        check("wd_timeout_err", b0.timeout_err, 1'b1);
        check("wd_ac_we", b0.ac_we, 1'b0);
        check("wd_y_we", b0.y_we, 1'b0);
        check("wd_op_done", b0.op_done, 1'b0);
        $display("op 0D x 0B -> timeout_err=%0b at T+17", b0.timeout_err);
        @(negedge clk);
        check("wd_ready", b0.op_ready, 1'b1);
        check("wd_err_pulse", b0.timeout_err, 1'b0);
        check("wd_no_ac_we", 16'(ac_we_cnt - a0), 16'd0);
        check("wd_no_flag_we", 16'(flag_we_cnt - f0), 16'd0);

        // Done on exactly the 15th WAIT cycle beats the watchdog.
        stub_delay = 15;
        accept_op(8'h0C, 8'h0B);
        repeat (16) @(negedge clk);
        check("edge_timeout", b0.timeout_err, 1'b0);
        check("edge_ac_we", b0.ac_we, 1'b1);
        check("edge_ac_wdata", b0.ac_wdata, 8'h84);
        check("edge_op_done", b0.op_done, 1'b1);
        $display("op 0C x 0B -> ac=%02h with done at watchdog limit", b0.ac_wdata);
        @(negedge clk);
        check("edge_ready", b0.op_ready, 1'b1);

        // Reset during WAIT; the stub's late done then hits an idle sequencer.
        stub_delay = 9;
        a0 = ac_we_cnt; d0 = op_done_cnt;
        accept_op(8'h0D, 8'h0B);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mrst_op_ready", b0.op_ready, 1'b1);
        check("mrst_stall", b0.stall, 1'b0);
        check("mrst_mcand", b0.mul_multiplicand, 8'h00);
        check("mrst_mplier", b0.mul_multiplier, 8'h00);
        repeat (15) @(negedge clk);
        check("mrst_no_ac_we", 16'(ac_we_cnt - a0), 16'd0);
        check("mrst_no_op_done", 16'(op_done_cnt - d0), 16'd0);
        $display("op 0D x 0B -> aborted by reset in WAIT");

        check("nh_y_we_never", 16'(nh_y_we_cnt), 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
